// File: rtl/posit_decode_pipe_pkg.sv
// Shared types and constants for the posit decode pipeline and its helpers.
package posit_decode_pipe_pkg;

   typedef enum logic [1:0] {
      NORMAL,
      ZERO,
      NAR
   } posit_special_e;

   localparam int unsigned POSIT32_EN      = 2;
   localparam int unsigned POSIT32_SCALE_W = 8;
   localparam int unsigned POSIT32_FRAC_W  = 27;

   // NaR is the sign bit alone; returned in a 64-bit container, slice to width.
   function automatic logic [63:0] posit_nar(input int unsigned width);
      logic [63:0] one;
      one = 64'd1;
      return one << (width - 1);
   endfunction

endpackage

// File: rtl/posit_decode_pipe_if.sv
// Valid/ready bundle carrying raw posits in and decoded fields out.
interface posit_decode_pipe_if #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned EN      = 2,
   parameter int unsigned SCALE_W = $clog2(WIDTH) + EN + 1,
   parameter int unsigned FRAC_W  = WIDTH - EN - 3
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   in_posit;
   logic               out_valid;
   logic               out_ready;
   logic               out_sign;
   logic [SCALE_W-1:0] out_scale;
   logic [FRAC_W:0]    out_mant;
   logic               out_zero;
   logic               out_nar;

   modport master (
      output in_valid, in_posit, out_ready,
      input  in_ready, out_valid, out_sign, out_scale, out_mant, out_zero, out_nar
   );

   modport slave (
      input  in_valid, in_posit, out_ready,
      output in_ready, out_valid, out_sign, out_scale, out_mant, out_zero, out_nar
   );
endinterface

// File: rtl/posit_decode_pipe_regime_count.sv
// Regime run-length counter: measures the leading run and strips it plus its terminator.
module posit_regime_count #(
   parameter int unsigned N   = 31,
   parameter int unsigned M_W = $clog2(N + 1)
) (
   input  logic [N-1:0]   bits,
   output logic           run_bit,
   output logic [M_W-1:0] run_len,
   output logic [N-1:0]   rest
);
   logic done;

   always_comb begin
      run_bit = bits[N-1];
      run_len = '0;
      done    = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (!done && (bits[N-1-i] == run_bit)) begin
            run_len = run_len + 1'b1;
         end else begin
            done = 1'b1;
         end
      end
      // A run filling every bit has no terminator and leaves nothing behind.
      if (32'(run_len) >= N) begin
         rest = '0;
      end else begin
         rest = bits << (32'(run_len) + 32'd1);
      end
   end
endmodule

// File: rtl/posit_decode_pipe.sv
// Two-stage posit unpacker: stage 1 captures sign/magnitude/specials, stage 2 decodes fields.
module posit_decode_pipe
   import posit_decode_pipe_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned EN      = POSIT32_EN,
   parameter int unsigned SCALE_W = $clog2(WIDTH) + EN + 1,
   parameter int unsigned FRAC_W  = WIDTH - EN - 3
) (
   input logic                clk,
   input logic                rst,
   posit_decode_pipe_if.slave bus
);
   localparam int unsigned N   = WIDTH - 1;
   localparam int unsigned M_W = $clog2(N + 1);
   localparam logic [63:0] NAR_PAT = posit_nar(WIDTH);

   logic           s1_valid;
   posit_special_e s1_special;
   logic           s1_sign;
   logic [N-1:0]   s1_mag;

   logic s2_load;
   logic s1_load;

   logic [WIDTH-1:0] neg_posit;
   posit_special_e   special_d;

   logic               run_bit;
   logic [M_W-1:0]     run_len;
   logic [N-1:0]       rest;
   logic [SCALE_W-1:0] k;
   logic [SCALE_W-1:0] scale_d;
   logic [EN-1:0]      exp_d;
   logic [FRAC_W-1:0]  frac_d;

   assign s2_load      = !bus.out_valid || bus.out_ready;
   assign s1_load      = !s1_valid || s2_load;
   assign bus.in_ready = s1_load;

   always_comb begin
      neg_posit = '0 - bus.in_posit;
      special_d = NORMAL;
      if (bus.in_posit == '0) begin
         special_d = ZERO;
      end else if (bus.in_posit == NAR_PAT[WIDTH-1:0]) begin
         special_d = NAR;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_special <= NORMAL;
         s1_sign    <= 1'b0;
         s1_mag     <= '0;
      end else if (s1_load) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_special <= special_d;
            s1_sign    <= bus.in_posit[WIDTH-1] && (special_d == NORMAL);
            s1_mag     <= bus.in_posit[WIDTH-1] ? neg_posit[N-1:0] : bus.in_posit[N-1:0];
         end
      end
   end

   posit_regime_count #(
      .N   (N),
      .M_W (M_W)
   ) u_regime (
      .bits    (s1_mag),
      .run_bit (run_bit),
      .run_len (run_len),
      .rest    (rest)
   );

   // Scale is built modulo 2^SCALE_W; low EN bits of k<<EN are zero so adding e is exact.
   always_comb begin
      k       = run_bit ? (SCALE_W'(run_len) - SCALE_W'(1)) : (SCALE_W'(0) - SCALE_W'(run_len));
      exp_d   = rest[N-1 -: EN];
      frac_d  = rest[N-1-EN -: FRAC_W];
      scale_d = (k << EN) + SCALE_W'(exp_d);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.out_valid <= 1'b0;
         bus.out_sign  <= 1'b0;
         bus.out_scale <= '0;
         bus.out_mant  <= '0;
         bus.out_zero  <= 1'b0;
         bus.out_nar   <= 1'b0;
      end else if (s2_load) begin
         bus.out_valid <= s1_valid;
         if (s1_valid) begin
            bus.out_zero <= (s1_special == ZERO);
            bus.out_nar  <= (s1_special == NAR);
            if (s1_special == NORMAL) begin
               bus.out_sign  <= s1_sign;
               bus.out_scale <= scale_d;
               bus.out_mant  <= {1'b1, frac_d};
            end else begin
               bus.out_sign  <= 1'b0;
               bus.out_scale <= '0;
               bus.out_mant  <= '0;
            end
         end
      end
   end
endmodule

// File: tb/tb_posit_decode_pipe.sv
// Directed bench for posit_decode_pipe at 32/2: vector table plus streaming, stall and reset sequences.
module tb_posit_decode_pipe;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned EN    = 2;
   localparam int unsigned SW    = 8;
   localparam int unsigned FW    = 27;

   typedef struct {
      logic [31:0] p;
      logic        s;
      int          sc;
      logic [27:0] m;
      logic        z;
      logic        n;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   vec_t vec[16];

   posit_decode_pipe_if #(.WIDTH(WIDTH), .EN(EN), .SCALE_W(SW), .FRAC_W(FW)) bus ();

   posit_decode_pipe #(.WIDTH(WIDTH), .EN(EN), .SCALE_W(SW), .FRAC_W(FW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_out(input string tag, input int i);
      logic [SW-1:0] sc;
      sc = SW'(vec[i].sc);
      chk({tag, " valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, " sign"},  64'(bus.out_sign),  64'(vec[i].s));
      chk({tag, " scale"}, 64'(bus.out_scale), 64'(sc));
      chk({tag, " mant"},  64'(bus.out_mant),  64'(vec[i].m));
      chk({tag, " zero"},  64'(bus.out_zero),  64'(vec[i].z));
      chk({tag, " nar"},   64'(bus.out_nar),   64'(vec[i].n));
   endtask

   initial begin
      int first;
      int last;
      int ri;

      checks = 0;
      errors = 0;
      vec[0]  = '{32'h40000000, 1'b0,    0, 28'h8000000, 1'b0, 1'b0};
      vec[1]  = '{32'h48000000, 1'b0,    1, 28'h8000000, 1'b0, 1'b0};
      vec[2]  = '{32'h50000000, 1'b0,    2, 28'h8000000, 1'b0, 1'b0};
      vec[3]  = '{32'hC0000000, 1'b1,    0, 28'h8000000, 1'b0, 1'b0};
      vec[4]  = '{32'h00000000, 1'b0,    0, 28'h0000000, 1'b1, 1'b0};
      vec[5]  = '{32'h80000000, 1'b0,    0, 28'h0000000, 1'b0, 1'b1};
      vec[6]  = '{32'h7FFFFFFF, 1'b0,  120, 28'h8000000, 1'b0, 1'b0};
      vec[7]  = '{32'h00000001, 1'b0, -120, 28'h8000000, 1'b0, 1'b0};
      vec[8]  = '{32'h44000000, 1'b0,    0, 28'hC000000, 1'b0, 1'b0};
      vec[9]  = '{32'h60000000, 1'b0,    4, 28'h8000000, 1'b0, 1'b0};
      vec[10] = '{32'h20000000, 1'b0,   -4, 28'h8000000, 1'b0, 1'b0};
      vec[11] = '{32'h3C000000, 1'b0,   -1, 28'hC000000, 1'b0, 1'b0};
      vec[12] = '{32'hBC000000, 1'b1,    0, 28'hC000000, 1'b0, 1'b0};
      vec[13] = '{32'h7FFFFFFE, 1'b0,  116, 28'h8000000, 1'b0, 1'b0};
      vec[14] = '{32'h00000003, 1'b0, -114, 28'h8000000, 1'b0, 1'b0};
      vec[15] = '{32'h40000001, 1'b0,    0, 28'h8000001, 1'b0, 1'b0};

      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_posit = '0;
      bus.out_ready = 1'b0;
      #12;
      chk("reset out_valid", 64'(bus.out_valid), 64'd0);
      chk("reset in_ready",  64'(bus.in_ready),  64'd1);
      chk("reset scale",     64'(bus.out_scale), 64'd0);
      chk("reset mant",      64'(bus.out_mant),  64'd0);
      chk("reset flags",     64'({bus.out_sign, bus.out_zero, bus.out_nar}), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Single transfers: exact two-cycle latency and decoded fields.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         bus.in_valid  = 1'b1;
         bus.in_posit  = vec[i].p;
         bus.out_ready = 1'b1;
         chk("single in_ready", 64'(bus.in_ready), 64'd1);
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         chk("latency early", 64'(bus.out_valid), 64'd0);
         @(posedge clk);
         #1;
         check_out($sformatf("vec%0d", i), i);
      end
      @(negedge clk);
      @(negedge clk);
      chk("drained", 64'(bus.out_valid), 64'd0);

      // Back-to-back stream.
      first = -1;
      last  = -1;
      ri    = 0;
      for (int cyc = 0; cyc < 40 && ri < 16; cyc++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            check_out($sformatf("stream%0d", ri), ri);
            if (first < 0) first = cyc;
            last = cyc;
            ri++;
         end
         if (cyc < 16) begin
            chk("stream in_ready", 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b1;
            bus.in_posit = vec[cyc].p;
         end else begin
            bus.in_valid = 1'b0;
         end
      end
      bus.in_valid = 1'b0;
      chk("stream count", 64'(ri), 64'd16);
      chk("stream gapless", 64'(last - first), 64'd15);
      @(negedge clk);
      @(negedge clk);

      // Backpressure: two held, third waits until out_ready rises.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_posit  = vec[1].p;
      chk("bp accept A", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      chk("bp accept B", 64'(bus.in_ready), 64'd1);
      bus.in_posit = vec[2].p;
      @(negedge clk);
      bus.in_posit = vec[3].p;
      chk("bp full in_ready", 64'(bus.in_ready), 64'd0);
      check_out("bp hold0", 1);
      for (int j = 0; j < 2; j++) begin
         @(negedge clk);
         chk("bp stall in_ready", 64'(bus.in_ready), 64'd0);
         check_out("bp hold", 1);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("bp comb in_ready", 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check_out("bp B", 2);
      @(negedge clk);
      check_out("bp C", 3);
      @(negedge clk);
      chk("bp empty", 64'(bus.out_valid), 64'd0);

      // Asynchronous reset with two posits in flight.
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_posit  = vec[6].p;
      @(negedge clk);
      bus.in_posit = vec[7].p;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("rst pre out_valid", 64'(bus.out_valid), 64'd1);
      chk("rst pre in_ready",  64'(bus.in_ready),  64'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("rst async out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst async scale",     64'(bus.out_scale), 64'd0);
      chk("rst async mant",      64'(bus.out_mant),  64'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      chk("rst post in_ready", 64'(bus.in_ready), 64'd1);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk);
         chk("rst no stale", 64'(bus.out_valid), 64'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
